// File: rtl/bus_xfer_ctrl.sv
// Bus transfer sequencer: drives one-hot source/destination strobes over IDLE/DRIVE/LATCH.
// Define BUS_XFER_QUEUE_EN to add a 2-entry request FIFO ahead of the FSM.
module bus_xfer_ctrl (
    input  logic        clock,
    input  logic        clear_n,
    input  logic        req_valid,
    input  logic [4:0]  req_src,
    input  logic [4:0]  req_dst,
    output logic        req_ready,
    output logic [23:0] src_out,
    output logic [23:0] dst_in,
    output logic        done,
    output logic        err,
    output logic        busy
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_DRIVE = 2'd1;
    localparam logic [1:0] ST_LATCH = 2'd2;
    localparam logic [4:0] MAX_CODE = 5'd23;

    logic [1:0] state_q, state_d;
    logic [4:0] src_q, src_d;
    logic [4:0] dst_q, dst_d;
    logic       err_q, err_d;
    logic       ready_en_q;

    logic       accept;
    logic       take;
    logic       head_valid;
    logic [4:0] head_src;
    logic [4:0] head_dst;

    // The FSM can start a new transfer from IDLE or straight out of LATCH.
    assign take   = (state_q == ST_IDLE) || (state_q == ST_LATCH);
    assign accept = req_valid & req_ready;

`ifdef BUS_XFER_QUEUE_EN
    logic [4:0] fifo_src_q [2];
    logic [4:0] fifo_dst_q [2];
    logic       wr_ptr_q;
    logic       rd_ptr_q;
    logic [1:0] count_q;
    logic       empty;
    logic       full;
    logic       push;
    logic       pop;

    assign empty = (count_q == 2'd0);
    assign full  = (count_q == 2'd2);
    // A full FIFO still accepts when the head is being consumed this cycle.
    assign req_ready  = ready_en_q & (~full | take);
    // An empty FIFO is bypassed so an idle FSM keeps single-cycle acceptance latency.
    assign head_valid = ~empty | accept;
    assign head_src   = empty ? req_src : fifo_src_q[rd_ptr_q];
    assign head_dst   = empty ? req_dst : fifo_dst_q[rd_ptr_q];
    assign pop        = take & ~empty;
    assign push       = accept & ~(take & empty);

    always_ff @(posedge clock) begin
        if (push) begin
            fifo_src_q[wr_ptr_q] <= req_src;
            fifo_dst_q[wr_ptr_q] <= req_dst;
        end
    end

    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (push) begin
                wr_ptr_q <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + 2'd1;
                2'b01:   count_q <= count_q - 2'd1;
                default: count_q <= count_q;
            endcase
        end
    end
`else
    assign req_ready  = ready_en_q & (state_q == ST_IDLE);
    assign head_valid = accept;
    assign head_src   = req_src;
    assign head_dst   = req_dst;
`endif

    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        dst_d   = dst_q;
        err_d   = 1'b0;
        case (state_q)
            ST_DRIVE: state_d = ST_LATCH;
            ST_LATCH: state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
        if (take && head_valid) begin
            if ((head_src <= MAX_CODE) && (head_dst <= MAX_CODE)) begin
                state_d = ST_DRIVE;
                src_d   = head_src;
                dst_d   = head_dst;
            end else begin
                state_d = ST_IDLE;
                err_d   = 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            state_q    <= ST_IDLE;
            src_q      <= '0;
            dst_q      <= '0;
            err_q      <= 1'b0;
            ready_en_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            src_q      <= src_d;
            dst_q      <= dst_d;
            err_q      <= err_d;
            ready_en_q <= 1'b1;
        end
    end

    assign src_out = ((state_q == ST_DRIVE) || (state_q == ST_LATCH)) ? (24'd1 << src_q) : '0;
    assign dst_in  = (state_q == ST_LATCH) ? (24'd1 << dst_q) : '0;
    assign done    = (state_q == ST_LATCH);
    assign busy    = (state_q != ST_IDLE);
    assign err     = err_q;

endmodule

// File: tb/tb_bus_xfer_ctrl.sv
// Scoreboard bench for bus_xfer_ctrl; reference model predicts per-request start edge arithmetically.
// Works in both builds (BUS_XFER_QUEUE_EN defined or not).
module tb_bus_xfer_ctrl;

    logic        clock;
    logic        clear_n;
    logic        req_valid;
    logic [4:0]  req_src;
    logic [4:0]  req_dst;
    logic        req_ready;
    logic [23:0] src_out;
    logic [23:0] dst_in;
    logic        done;
    logic        err;
    logic        busy;

    bus_xfer_ctrl dut (
        .clock    (clock),
        .clear_n  (clear_n),
        .req_valid(req_valid),
        .req_src  (req_src),
        .req_dst  (req_dst),
        .req_ready(req_ready),
        .src_out  (src_out),
        .dst_in   (dst_in),
        .done     (done),
        .err      (err),
        .busy     (busy)
    );

    // a: acceptance edge, t: edge the FSM takes it, fr: first edge it can take the next one,
    // ev: cycle in which done (valid) or err (invalid) is expected.
    typedef struct {
        int       a;
        int       t;
        int       fr;
        int       ev;
        logic     ok;
        logic [4:0] s;
        logic [4:0] d;
    } item_t;

    item_t sb[$];
    int    last_free;
    int    cyc;
    int    tests;
    int    fails;
    bit    in_reset;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) cyc = cyc + 1;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests = tests + 1;
        if (got !== exp) begin
            fails = fails + 1;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Monitor: per-cycle comparison against the model, plus pop-and-compare on done/err.
    logic [23:0] e_src, e_dst;
    logic        e_busy, e_done, e_err, e_ready, avail;
    int          fcnt, n;
    item_t       it;

    always @(negedge clock) begin
        if (!in_reset) begin
            n      = cyc;
            e_src  = '0;
            e_dst  = '0;
            e_busy = 1'b0;
            e_done = 1'b0;
            e_err  = 1'b0;
            fcnt   = 0;
            avail  = 1'b1;
            foreach (sb[i]) begin
                if (sb[i].ok && n >= sb[i].t && n <= sb[i].t + 1) begin
                    e_busy = 1'b1;
                    e_src  = 24'd1 << sb[i].s;
                    if (n == sb[i].t + 1) begin
                        e_dst  = 24'd1 << sb[i].d;
                        e_done = 1'b1;
                    end
                end
                if (!sb[i].ok && n == sb[i].t) e_err = 1'b1;
                if (sb[i].a <= n && sb[i].t > n) fcnt = fcnt + 1;
                if (sb[i].t <= n && sb[i].fr > n + 1) avail = 1'b0;
            end
`ifdef BUS_XFER_QUEUE_EN
            e_ready = (fcnt < 2) || avail;
`else
            e_ready = !e_busy;
`endif
            check("src_out", src_out, e_src);
            check("dst_in", dst_in, e_dst);
            check("busy", busy, e_busy);
            check("done", done, e_done);
            check("err", err, e_err);
            check("req_ready", req_ready, e_ready);

            if (done || err) begin
                if (sb.size() == 0) begin
                    tests = tests + 1;
                    fails = fails + 1;
                    $display("FAIL spurious_event: got done=%0b err=%0b expected no event (cycle %0d)", done, err, n);
                end else begin
                    it = sb.pop_front();
                    check("event_kind_done", done, it.ok);
                    check("event_cycle", n, it.ev);
                end
            end
            while (sb.size() > 0 && sb[0].ev < n) begin
                it = sb.pop_front();
                tests = tests + 1;
                fails = fails + 1;
                $display("FAIL missed_event: got none expected event at cycle %0d (src %0d dst %0d)", it.ev, it.s, it.d);
            end

            if (req_valid && req_ready) begin
                it.a  = n + 1;
                it.t  = (it.a > last_free) ? it.a : last_free;
                it.ok = (req_src <= 5'd23) && (req_dst <= 5'd23);
                it.fr = it.ok ? it.t + 2 : it.t + 1;
                it.ev = it.ok ? it.t + 1 : it.t;
                it.s  = req_src;
                it.d  = req_dst;
                sb.push_back(it);
                last_free = it.fr;
            end
        end
    end

    // Called at posedge+1; asserts reset immediately, holds it, releases mid-cycle.
    task automatic apply_reset();
        #1;
        in_reset = 1'b1;
        clear_n  = 1'b0;
        #1;
        check("rst_src_out", src_out, 24'd0);
        check("rst_dst_in", dst_in, 24'd0);
        check("rst_done", done, 1'b0);
        check("rst_err", err, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_ready", req_ready, 1'b0);
        repeat (2) @(posedge clock);
        #1;
        check("rst_hold_busy", busy, 1'b0);
        check("rst_hold_ready", req_ready, 1'b0);
        sb.delete();
        last_free = 0;
        @(negedge clock);
        #1;
        clear_n = 1'b1;
        #1;
        check("ready_at_release", req_ready, 1'b0);
        @(posedge clock);
        #1;
        check("ready_first_edge", req_ready, 1'b1);
        check("idle_after_release", busy, 1'b0);
        in_reset = 1'b0;
    endtask

    task automatic send(input logic [4:0] s, input logic [4:0] d);
        bit got;
        got       = 1'b0;
        req_valid = 1'b1;
        req_src   = s;
        req_dst   = d;
        for (int i = 0; i < 30 && !got; i++) begin
            @(negedge clock);
            if (req_ready) got = 1'b1;
            @(posedge clock);
            #1;
        end
        req_valid = 1'b0;
        req_src   = 5'($urandom_range(0, 31));
        req_dst   = 5'($urandom_range(0, 31));
        if (!got) begin
            tests = tests + 1;
            fails = fails + 1;
            $display("FAIL accept_timeout: got no acceptance expected acceptance of src %0d dst %0d", s, d);
        end
    endtask

    task automatic wait_idle();
        bit idle;
        idle = 1'b0;
        for (int i = 0; i < 80 && !idle; i++) begin
            @(posedge clock);
            #1;
            if (sb.size() == 0 && !busy) idle = 1'b1;
        end
        if (!idle) begin
            tests = tests + 1;
            fails = fails + 1;
            $display("FAIL idle_timeout: got %0d pending expected 0", sb.size());
        end
    endtask

    initial begin
        int tgt;
        tests     = 0;
        fails     = 0;
        cyc       = 0;
        last_free = 0;
        in_reset  = 1'b1;
        clear_n   = 1'b0;
        req_valid = 1'b0;
        req_src   = '0;
        req_dst   = '0;
        @(posedge clock);
        #1;
        apply_reset();

        send(5'd20, 5'd20); wait_idle();
        send(5'd5,  5'd23); wait_idle();
        send(5'd25, 5'd3);  wait_idle();
        send(5'd3,  5'd3);  wait_idle();
        send(5'd7,  5'd31); wait_idle();
        send(5'd0,  5'd0);  wait_idle();
        send(5'd23, 5'd22); wait_idle();

        // Three requests with valid held high.
        send(5'd1, 5'd2);
        send(5'd16, 5'd17);
        send(5'd23, 5'd0);
        wait_idle();

        // Mixed burst including an invalid entry between valid ones.
        send(5'd9, 5'd10);
        send(5'd30, 5'd1);
        send(5'd11, 5'd12);
        send(5'd13, 5'd14);
        wait_idle();

        // Reset during LATCH aborts the transfer with no done.
        send(5'd21, 5'd7);
        tgt = (sb.size() > 0) ? sb[$].t + 1 : cyc;
        for (int i = 0; i < 20 && cyc < tgt; i++) begin
            @(posedge clock);
            #1;
        end
        check("latch_before_reset", done, 1'b1);
        apply_reset();
        check("post_reset_pending", sb.size(), 0);

        for (int i = 0; i < 400; i++) begin
            req_valid = ($urandom_range(0, 99) < 55);
            req_src   = ($urandom_range(0, 9) == 0) ? 5'($urandom_range(24, 31)) : 5'($urandom_range(0, 23));
            req_dst   = ($urandom_range(0, 9) == 0) ? 5'($urandom_range(24, 31)) : 5'($urandom_range(0, 23));
            @(posedge clock);
            #1;
        end
        req_valid = 1'b0;
        wait_idle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/bus_xfer_ctrl.md
BUS_XFER_CTRL -- requirements
Module: bus_xfer_ctrl

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset; all state SHALL change on the rising edge of clock, except on assertion of clear_n.
REQ-002 clock  in  1  rising-edge clock.
REQ-003 clear_n  in  1  asynchronous active-low reset.
REQ-004 req_valid  in  1  a transfer request is present.
REQ-005 req_src  in  5  source code: 0-15=R0-R15, 16=HI, 17=LO, 18=Zhigh, 19=Zlow, 20=PC, 21=MDR, 22=InPort, 23=C.
REQ-006 req_dst  in  5  destination code: 0-15=R0-R15, 16=HI, 17=LO, 18=PC, 19=MDR, 20=MAR, 21=IR, 22=Y, 23=OutPort.
REQ-007 req_ready  out  1  the request is accepted on a cycle where req_valid and req_ready are both 1.
REQ-008 src_out  out  24  one-hot bus source enables; bit n corresponds to source code n.
REQ-009 dst_in  out  24  one-hot register load enables; bit n corresponds to destination code n.
REQ-010 done  out  1  one-cycle pulse when a transfer completes.
REQ-011 err  out  1  one-cycle pulse when an accepted request has an invalid code.
REQ-012 busy  out  1  high whenever the FSM is not in IDLE.

Function
REQ-013 The FSM SHALL have three states: IDLE, DRIVE and LATCH.
REQ-014 On acceptance in IDLE, if req_src<=23 and req_dst<=23, the FSM SHALL capture both codes and go to DRIVE.
REQ-015 In DRIVE, src_out SHALL equal one-hot(src); dst_in SHALL be 0; the FSM SHALL go to LATCH next cycle.
REQ-016 In LATCH, src_out SHALL hold one-hot(src) and dst_in SHALL equal one-hot(dst).
REQ-017 done SHALL be 1 during LATCH only.
REQ-018 From LATCH, the FSM SHALL return to IDLE unless a queued request is pending (see REQ-025).
REQ-019 Latency SHALL be as follows: acceptance at edge k gives DRIVE in cycle k+1 and LATCH/done in cycle k+2.
REQ-020 If req_src>23 or req_dst>23, the FSM SHALL assert no strobes, pulse err in the cycle after acceptance, and stay in IDLE.
REQ-021 At most one bit of src_out and at most one bit of dst_in SHALL be 1 in any cycle.
REQ-022 All strobes SHALL be 0 in IDLE.
REQ-023 The captured src/dst codes SHALL be immune to input changes after acceptance.
REQ-024 Without the queue, req_ready SHALL be 1 only in IDLE.
REQ-025 With the queue, LATCH SHALL go directly to DRIVE when the queue is non-empty, giving back-to-back transfers with no IDLE gap.
REQ-026 If src==dst (both codes 0-15), the transfer SHALL proceed normally; it is legal.

Reset
REQ-027 While clear_n=0, the FSM SHALL be in IDLE, the queue SHALL be empty, and src_out, dst_in, done, err and busy SHALL be 0.
REQ-028 While clear_n=0, req_ready SHALL be 0; it SHALL take its normal value from the first clock edge after release.
REQ-029 Reset asserted in DRIVE or LATCH SHALL abort the transfer immediately with no done pulse, and queued requests SHALL be discarded.

Configuration
REQ-030 The feature SHALL be controlled by the macro BUS_XFER_QUEUE_EN.
REQ-031 When BUS_XFER_QUEUE_EN is defined, the block SHALL include a 2-entry FIFO ahead of the FSM.
REQ-032 With the FIFO, req_ready SHALL be 1 when the FIFO is not full, in any FSM state.
REQ-033 Invalid requests SHALL be checked when they leave the FIFO, pulsing err in the cycle a DRIVE would have started.
REQ-034 A simultaneous push and pop on a full FIFO SHALL be allowed.
REQ-035 When BUS_XFER_QUEUE_EN is undefined, the block SHALL have no FIFO and REQ-024 SHALL apply.

Verification
REQ-036 Request src=20, dst=20 (PC->MAR) -> src_out=0x100000 in cycles k+1 and k+2; dst_in=0x100000 in cycle k+2 only; done in cycle k+2.
REQ-037 Request src=5, dst=23 -> src_out=0x000020 for 2 cycles; dst_in=0x800000 in the 2nd cycle; busy=1 for 2 cycles.
REQ-038 Request src=25, dst=3 -> err pulse in cycle k+1; src_out=0 and dst_in=0 throughout; req_ready=1 again in cycle k+1.
REQ-039 clear_n driven low mid-LATCH (src=21, dst=7) -> all outputs 0 asynchronously; no done pulse; IDLE after release.
REQ-040 With BUS_XFER_QUEUE_EN, 3 requests presented on consecutive cycles -> req_ready=0 only while the FIFO is full; 3 done pulses, 2 cycles apart, with no idle cycle between.
REQ-041 Without the macro, req_valid held high over 3 requests -> each accepted only in IDLE; one idle cycle between transfers.
